lcd_frame_writer: RTL and testbench

//  Display-side receiver for the PPU pixel stream (px_out strobe + 2-bit shade px).

---
 rtl/lcd_frame_writer.sv | 144 ++++++++++++++
 tb/tb_lcd_frame_writer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_writer.sv
// Display-side receiver: packs the PPU 2bpp pixel stream into bytes and writes
// them to the framebuffer through a small FIFO and a req/ack write port.
module lcd_frame_writer #(
  parameter int unsigned WIDTH      = 160,
  parameter int unsigned HEIGHT     = 144,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADR_W      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             disp_on,
  input  logic             px_out,
  input  logic [1:0]       px,
  input  logic             vsync,
  output logic [ADR_W-1:0] fb_adr,
  output logic [7:0]       fb_dout,
  output logic             fb_we,
  input  logic             fb_ack,
  output logic             frame_done,
  output logic             overflow
);

  localparam int unsigned XW       = $clog2(WIDTH);
  localparam int unsigned YW       = $clog2(HEIGHT);
  localparam int unsigned PW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = PW + 1;
  localparam int unsigned LAST_ADR = WIDTH * HEIGHT / 4 - 1;

  logic [XW-1:0]    x_q, cur_x;
  logic [YW-1:0]    y_q, cur_y;
  logic [ADR_W-1:0] adr_q, cur_adr, adr_inc;
  logic [5:0]       acc_q, cur_acc;
  logic             disp_q;

  logic [ADR_W-1:0] mem_adr [FIFO_DEPTH];
  logic [7:0]       mem_dat [FIFO_DEPTH];
  logic [PW-1:0]    rd_q, wr_q, rd_next;
  logic [CW-1:0]    count_q, remain, count_next;

  logic             accept, byte_done, line_end, frame_end;
  logic             pop, full, push, drop;
  logic [7:0]       new_byte;
  logic [ADR_W-1:0] head_adr;
  logic [7:0]       head_dat;

  // Pixel position seen by the current strobe; vsync restarts it at (0,0)
  always_comb begin
    accept    = disp_on && px_out;
    cur_x     = vsync ? '0 : x_q;
    cur_y     = vsync ? '0 : y_q;
    cur_adr   = vsync ? '0 : adr_q;
    cur_acc   = vsync ? '0 : acc_q;
    byte_done = accept && (cur_x[1:0] == 2'b11);
    line_end  = accept && (cur_x == XW'(WIDTH - 1));
    frame_end = line_end && (cur_y == YW'(HEIGHT - 1));
    new_byte  = {cur_acc, px};
    adr_inc   = (cur_adr == ADR_W'(LAST_ADR)) ? '0 : cur_adr + ADR_W'(1);
  end

  // FIFO bookkeeping; a pop on the same edge frees room for a push into a full FIFO
  always_comb begin
    pop        = fb_we && fb_ack;
    full       = (count_q == CW'(FIFO_DEPTH));
    push       = byte_done && (!full || pop);
    drop       = byte_done && full && !pop;
    rd_next    = rd_q + PW'(pop);
    remain     = count_q - CW'(pop);
    count_next = remain + CW'(push);
    head_adr   = mem_adr[rd_next];
    head_dat   = mem_dat[rd_next];
    if (remain == '0) begin
      head_adr = cur_adr;
      head_dat = new_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q        <= '0;
      y_q        <= '0;
      adr_q      <= '0;
      acc_q      <= '0;
      disp_q     <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      disp_q     <= disp_on;
      frame_done <= frame_end;
      if (drop) begin
        overflow <= 1'b1;
      end else if (disp_on && !disp_q) begin
        overflow <= 1'b0;
      end
      if (!disp_on) begin
        x_q   <= '0;
        y_q   <= '0;
        adr_q <= '0;
        acc_q <= '0;
      end else if (accept) begin
        x_q   <= line_end ? '0 : cur_x + XW'(1);
        y_q   <= frame_end ? '0 : (line_end ? cur_y + YW'(1) : cur_y);
        acc_q <= {cur_acc[3:0], px};
        adr_q <= byte_done ? adr_inc : cur_adr;
      end else if (vsync) begin
        x_q   <= '0;
        y_q   <= '0;
        adr_q <= '0;
        acc_q <= '0;
      end
    end
  end

  // Write port: head of the FIFO is held in output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      fb_we   <= 1'b0;
      fb_adr  <= '0;
      fb_dout <= '0;
    end else begin
      rd_q    <= rd_next;
      count_q <= count_next;
      fb_we   <= (count_next != '0);
      if (push) begin
        wr_q <= wr_q + PW'(1);
      end
      if (count_next != '0) begin
        fb_adr  <= head_adr;
        fb_dout <= head_dat;
      end
    end
  end

  // FIFO storage needs no reset; only entries counted by count_q are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_adr[wr_q] <= cur_adr;
      mem_dat[wr_q] <= new_byte;
    end
  end

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Randomized scoreboard bench for lcd_frame_writer against a frame-position
// reference model.
module tb_lcd_frame_writer;
  localparam int unsigned WIDTH      = 160;
  localparam int unsigned HEIGHT     = 144;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned ADR_W      = 13;
  localparam int          NPIX       = WIDTH * HEIGHT;

  logic             clk = 1'b0;
  logic             reset, disp_on, px_out, vsync, fb_ack;
  logic [1:0]       px;
  logic [ADR_W-1:0] fb_adr;
  logic [7:0]       fb_dout;
  logic             fb_we, frame_done, overflow;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [7:0]       data;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  pos, part, mocc;
  int  nwr = 0;
  int  nfd = 0;
  int  last_adr = -1;
  int  last_dat = -1;
  bit  ovf_m, fd_m, prev_disp;
  bit  model_valid = 1'b0;

  lcd_frame_writer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .FIFO_DEPTH(FIFO_DEPTH), .ADR_W(ADR_W)
  ) dut (
    .clk(clk), .reset(reset), .disp_on(disp_on), .px_out(px_out), .px(px),
    .vsync(vsync), .fb_adr(fb_adr), .fb_dout(fb_dout), .fb_we(fb_we),
    .fb_ack(fb_ack), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluated at negedge for the upcoming posedge
  always @(negedge clk) begin
    bit pop, drop;
    if (model_valid) begin
      check("fb_we", int'(fb_we), int'(mocc > 0));
      check("overflow", int'(overflow), int'(ovf_m));
      check("frame_done", int'(frame_done), int'(fd_m));
    end
    if (reset) begin
      pos = 0; part = 0; mocc = 0;
      ovf_m = 1'b0; fd_m = 1'b0; prev_disp = 1'b0;
      sb.delete();
      model_valid = 1'b1;
    end else begin
      pop  = (mocc > 0) && fb_ack;
      drop = 1'b0;
      fd_m = 1'b0;
      if (!disp_on) begin
        pos = 0; part = 0;
      end else begin
        if (vsync) begin
          pos = 0; part = 0;
        end
        if (px_out) begin
          part = ((part << 2) | int'(px)) & 'hFF;
          if (pos % 4 == 3) begin
            if (mocc < FIFO_DEPTH || pop) begin
              wr_t e;
              e.adr  = ADR_W'(pos / 4);
              e.data = 8'(part);
              sb.push_back(e);
              mocc++;
            end else begin
              drop = 1'b1;
            end
          end
          if (pos == NPIX - 1) fd_m = 1'b1;
          pos = (pos + 1) % NPIX;
        end
      end
      if (pop) mocc--;
      if (drop) ovf_m = 1'b1;
      else if (disp_on && !prev_disp) ovf_m = 1'b0;
      prev_disp = disp_on;
    end
  end

  // Monitor: every accepted write is popped from the scoreboard and compared
  always @(negedge clk) begin
    if (model_valid && !reset) begin
      if (frame_done) nfd++;
      if (fb_we && fb_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_write_adr", int'(fb_adr), -1);
        end else begin
          wr_t e;
          e = sb.pop_front();
          check("wr_adr", int'(fb_adr), int'(e.adr));
          check("wr_data", int'(fb_dout), int'(e.data));
        end
        nwr++;
        last_adr = int'(fb_adr);
        last_dat = int'(fb_dout);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    px_out = 1'b0;
    repeat (n) step();
  endtask

  task automatic pix(input logic [1:0] v);
    px_out = 1'b1;
    px     = v;
    step();
    px_out = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int w0, f0;
    reset = 1'b1; disp_on = 1'b0; px_out = 1'b0; px = 2'd0; vsync = 1'b0; fb_ack = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_adr", int'(fb_adr), 0);
    check("rst_fb_dout", int'(fb_dout), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_done", int'(frame_done), 0);

    // single byte 3,2,1,0 -> E4 at address 0
    disp_on = 1'b1; fb_ack = 1'b1;
    w0 = nwr;
    pix(2'd3); pix(2'd2); pix(2'd1); pix(2'd0);
    idle(4);
    check("t1_writes", nwr - w0, 1);
    check("t1_adr", last_adr, 0);
    check("t1_data", last_dat, 'hE4);

    // full frame with continuous ack, then wrap to address 0
    do_reset();
    w0 = nwr; f0 = nfd;
    for (int i = 0; i < NPIX; i++) pix(2'($urandom));
    idle(4);
    check("t2_writes", nwr - w0, NPIX / 4);
    check("t2_last_adr", last_adr, NPIX / 4 - 1);
    check("t2_frame_done", nfd - f0, 1);
    for (int i = 0; i < 4; i++) pix(2'($urandom));
    idle(4);
    check("t2_wrap_adr", last_adr, 0);

    // second line starts at address 40
    do_reset();
    w0 = nwr;
    for (int i = 0; i < 160; i++) pix(2'd0);
    for (int i = 0; i < 4; i++) pix(2'd3);
    idle(4);
    check("t3_writes", nwr - w0, 41);
    check("t3_adr", last_adr, 40);
    check("t3_data", last_dat, 'hFF);

    // FIFO overflow with ack held low
    do_reset();
    fb_ack = 1'b0;
    for (int i = 0; i < 20; i++) pix(2'($urandom));
    idle(2);
    check("t4_overflow", int'(overflow), 1);
    check("t4_we_held", int'(fb_we), 1);
    check("t4_adr_held", int'(fb_adr), 0);
    w0 = nwr;
    fb_ack = 1'b1;
    idle(8);
    check("t4_writes", nwr - w0, 4);
    check("t4_last_adr", last_adr, 3);

    // partial byte discarded by disp_on low; rising edge clears overflow
    w0 = nwr;
    pix(2'd2); pix(2'd3);
    disp_on = 1'b0;
    idle(3);
    disp_on = 1'b1;
    pix(2'd1); pix(2'd1); pix(2'd1); pix(2'd1);
    idle(4);
    check("t5_writes", nwr - w0, 1);
    check("t5_adr", last_adr, 0);
    check("t5_data", last_dat, 'h55);
    check("t5_overflow", int'(overflow), 0);

    // reset with three pending writes
    do_reset();
    fb_ack = 1'b0;
    for (int i = 0; i < 12; i++) pix(2'($urandom));
    idle(1);
    check("t6_we_before", int'(fb_we), 1);
    do_reset();
    check("t6_we_after", int'(fb_we), 0);
    check("t6_ovf_after", int'(overflow), 0);
    check("t6_fd_after", int'(frame_done), 0);
    w0 = nwr;
    fb_ack = 1'b1;
    for (int i = 0; i < 4; i++) pix(2'($urandom));
    idle(4);
    check("t6_writes", nwr - w0, 1);
    check("t6_adr", last_adr, 0);

    // random traffic: display gating, vsync, bursty strobes and ack
    do_reset();
    for (int i = 0; i < 6000; i++) begin
      disp_on = ($urandom % 60) != 0;
      vsync   = ($urandom % 150) == 0;
      px_out  = ($urandom % 4) != 0;
      px      = 2'($urandom);
      fb_ack  = (i < 4000) ? (($urandom % 3) != 0) : (($urandom % 5) == 0);
      step();
    end
    disp_on = 1'b1; vsync = 1'b0; fb_ack = 1'b1;
    idle(12);
    check("rand_sb_empty", sb.size(), 0);
    check("rand_we_idle", int'(fb_we), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
